// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, queue entry and the NOP encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
  } fdq_entry_t;

  localparam word_t NOP_INSTR = 32'h0;

endpackage

// File: rtl/fdq_ptr_ctrl.sv
// Read/write pointers, occupancy and push/pop enables for fetch_decode_queue.
// Optional zero-latency bypass selected by FDQ_BYPASS_EN.
module fdq_ptr_ctrl #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dec_ready,
  input  logic             freeze,
  input  logic             flush,
  output logic             push,
  output logic             pop,
  output logic             bypass,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             take;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_W'(DEPTH));
`ifdef FDQ_BYPASS_EN
    bypass = empty & ihit & ~flush;
`else
    bypass = 1'b0;
`endif
    // take: decode accepts whatever is presented at the head (stored or bypassed)
    take = (~empty | bypass) & dec_ready & ~freeze & ~flush;
    pop  = ~empty & take;
    // A bypassed word consumed in the same cycle never enters storage
    push = ihit & ~full & ~flush & ~(bypass & take);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr = rd_ptr_q;
  assign wr_ptr = wr_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry fetch-to-decode instruction queue with flush, freeze and full backpressure.
// Define FDQ_BYPASS_EN for a zero-latency path from fetch to decode when empty.
module fetch_decode_queue
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      npc_in,
  output logic             full,
  input  logic             dec_ready,
  input  logic             freeze,
  input  logic             flush,
  output logic             valid_out,
  output logic [31:0]      instr_out,
  output logic [31:0]      npc_out,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             push;
  logic             pop;
  logic             bypass;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  fdq_entry_t       mem_q [DEPTH];
  fdq_entry_t       head;

  fdq_ptr_ctrl #(
    .DEPTH(DEPTH)
  ) u_ptr_ctrl (
    .CLK      (CLK),
    .RST      (RST),
    .ihit     (ihit),
    .dec_ready(dec_ready),
    .freeze   (freeze),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .bypass   (bypass),
    .rd_ptr   (rd_ptr),
    .wr_ptr   (wr_ptr),
    .count    (count),
    .full     (full)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr] <= '{instr: instr_in, npc: npc_in};
    end
  end

  always_comb begin
    head = '{instr: NOP_INSTR, npc: '0};
    if (bypass) begin
      head = '{instr: instr_in, npc: npc_in};
    end else if (count != '0) begin
      head = mem_q[rd_ptr];
    end
    valid_out = (count != '0) | bypass;
    instr_out = head.instr;
    npc_out   = head.npc;
  end

  // pop only advances the pointer inside the controller
  logic unused_pop;
  assign unused_pop = pop;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: vector table, corner sequences, random vs model.
module tb_fetch_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef FDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dec_ready, freeze, flush;
  logic [31:0]      instr_in, npc_in;
  logic             full, valid_out;
  logic [31:0]      instr_out, npc_out;
  logic [CNT_W-1:0] count;

  int passed = 0;
  int total  = 0;

  fetch_decode_queue #(
    .DEPTH(DEPTH)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ihit     (ihit),
    .instr_in (instr_in),
    .npc_in   (npc_in),
    .full     (full),
    .dec_ready(dec_ready),
    .freeze   (freeze),
    .flush    (flush),
    .valid_out(valid_out),
    .instr_out(instr_out),
    .npc_out  (npc_out),
    .count    (count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ihit;
    logic        dec_ready;
    logic [31:0] instr;
    int          exp_count;
    logic        exp_full;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic ih, input logic dr, input logic fz, input logic fl,
                       input logic [31:0] ins, input logic [31:0] np);
    ihit = ih; dec_ready = dr; freeze = fz; flush = fl; instr_in = ins; npc_in = np;
  endtask

  // Clock one cycle with given inputs, then look just after the edge
  task automatic step(input logic ih, input logic dr, input logic fz, input logic fl,
                      input logic [31:0] ins);
    @(negedge CLK);
    drive(ih, dr, fz, fl, ins, ins + 32'd4);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask

  // Reference model: plain FIFO of {instr,npc}
  logic [63:0] mq [$];

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    #1;
    chk("reset_valid", 64'(valid_out), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_instr", 64'(instr_out), 64'd0);
    chk("reset_npc", 64'(npc_out), 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Fill past capacity, then drain while fetch keeps pushing 0x2001_0006
    tbl[0] = '{1'b1, 1'b0, 32'h2001_0001, 1, 1'b0, 32'h2001_0001};
    tbl[1] = '{1'b1, 1'b0, 32'h2001_0002, 2, 1'b0, 32'h2001_0001};
    tbl[2] = '{1'b1, 1'b0, 32'h2001_0003, 3, 1'b0, 32'h2001_0001};
    tbl[3] = '{1'b1, 1'b0, 32'h2001_0004, 4, 1'b1, 32'h2001_0001};
    tbl[4] = '{1'b1, 1'b0, 32'h2001_0005, 4, 1'b1, 32'h2001_0001};
    tbl[5] = '{1'b1, 1'b1, 32'h2001_0006, 3, 1'b0, 32'h2001_0002};
    tbl[6] = '{1'b1, 1'b1, 32'h2001_0006, 3, 1'b0, 32'h2001_0003};
    tbl[7] = '{1'b1, 1'b1, 32'h2001_0006, 3, 1'b0, 32'h2001_0004};
    tbl[8] = '{1'b1, 1'b1, 32'h2001_0006, 3, 1'b0, 32'h2001_0006};
    tbl[9] = '{1'b1, 1'b1, 32'h2001_0006, 3, 1'b0, 32'h2001_0006};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].ihit, tbl[i].dec_ready, 1'b0, 1'b0, tbl[i].instr);
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_full", i), 64'(full), 64'(tbl[i].exp_full));
      chk($sformatf("tbl%0d_valid", i), 64'(valid_out), 64'd1);
      chk($sformatf("tbl%0d_instr", i), 64'(instr_out), 64'(tbl[i].exp_instr));
      chk($sformatf("tbl%0d_npc", i), 64'(npc_out), 64'(tbl[i].exp_instr + 32'd4));
    end

    // Flush beats same-cycle push and pop
    step(0, 1, 0, 0, 0);
    chk("pre_flush_count", 64'(count), 64'd2);
    step(1, 1, 0, 1, 32'hDEAD_0001);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(valid_out), 64'd0);
    chk("flush_instr", 64'(instr_out), 64'd0);
    step(0, 0, 0, 0, 0);
    chk("flush_nostore", 64'(count), 64'd0);

    // Freeze holds the head while fetch fills the queue
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 32'h3000_0000 + 32'(i));
    chk("frz_pre_count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 32'h3000_0004);
      chk($sformatf("frz%0d_instr", i), 64'(instr_out), 64'h3000_0001);
      chk($sformatf("frz%0d_count", i), 64'(count), 64'd4);
      chk($sformatf("frz%0d_full", i), 64'(full), 64'd1);
    end
    step(0, 1, 0, 0, 0);
    chk("frz_release_instr", 64'(instr_out), 64'h3000_0002);
    chk("frz_release_count", 64'(count), 64'd3);

    // Asynchronous reset between edges
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    #1;
    chk("async_valid", 64'(valid_out), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_full", 64'(full), 64'd0);
    #2;
    RST = 1'b0;

    // Empty queue with a fetch hit and decode ready
    @(negedge CLK);
    drive(1, 1, 0, 0, 32'h8C22_0004, 32'h0000_1008);
    #1;
    chk("byp_valid", 64'(valid_out), BYP ? 64'd1 : 64'd0);
    chk("byp_instr", 64'(instr_out), BYP ? 64'h8C22_0004 : 64'd0);
    @(posedge CLK);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("byp_next_count", 64'(count), BYP ? 64'd0 : 64'd1);
    chk("byp_next_instr", 64'(instr_out), BYP ? 64'd0 : 64'h8C22_0004);

    // Random traffic against the FIFO model
    do_reset();
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      int          cnt;
      bit          byp, take;
      logic [31:0] ei, en;
      @(negedge CLK);
      drive(($urandom_range(9) < 7), $urandom_range(1), ($urandom_range(4) == 0),
            ($urandom_range(19) == 0), $urandom, $urandom);
      cnt  = mq.size();
      byp  = BYP && cnt == 0 && ihit && !flush;
      ei   = cnt != 0 ? mq[0][63:32] : (byp ? instr_in : 32'd0);
      en   = cnt != 0 ? mq[0][31:0]  : (byp ? npc_in : 32'd0);
      #1;
      chk("rnd_count", 64'(count), 64'(cnt));
      chk("rnd_full", 64'(full), 64'(cnt == int'(DEPTH)));
      chk("rnd_valid", 64'(valid_out), 64'(cnt != 0 || byp));
      chk("rnd_instr", 64'(instr_out), 64'(ei));
      chk("rnd_npc", 64'(npc_out), 64'(en));
      @(posedge CLK);
      take = (cnt != 0 || byp) && dec_ready && !freeze && !flush;
      if (flush) begin
        mq.delete();
      end else if (!(byp && take)) begin
        if (take) void'(mq.pop_front());
        if (ihit && cnt < int'(DEPTH)) mq.push_back({instr_in, npc_in});
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
